fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_pc_reg.sv | 22 ++
 rtl/fetch.sv | 133 +++++++++++++
 tb/tb_fetch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state
// encodings, the HALT opcode and the PC step size.
package fetch_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [4:0]        OPC_HALT = 5'b00000;
  localparam logic [DATA_W-1:0] PC_INC   = 16'd2;

  // Major opcode field of an instruction word matches HALT
  function automatic logic is_halt(input logic [DATA_W-1:0] w);
    return (w[15:11] == OPC_HALT);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Generic async-reset register with load enable and configurable
// reset value; used for the PC, the instruction slot and pc_inc.
module pc_reg #(
  parameter int                 DATA_W    = 16,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  // Load on enable, return to the reset value asynchronously
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      o_q <= RESET_VAL;
    else if (i_en)
      o_q <= i_d;
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: issues reads at the current PC, captures one
// instruction into a single output slot, honours decode backpressure and
// downstream redirects, and flags misaligned redirect targets.
// Optional feature: define FETCH_HALT_EN to stop fetching after a HALT
// opcode (bits[15:11] == 5'b00000) until a redirect or reset.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction,
  output logic [15:0] pc_inc,
  output logic        inst_valid,
  output logic        halted,
  output logic        err
);

  state_t      r_state;
  logic        r_inst_valid;
  logic        r_err;
`ifdef FETCH_HALT_EN
  logic        r_halted;
`endif

  logic [15:0] w_pc;
  logic [15:0] w_pc_next_seq;
  logic [15:0] w_pc_d;
  logic        w_pc_en;
  logic        w_accept;

  // A word is taken only while requesting, with the slot free, and never
  // in a redirect cycle (the redirect discards whatever memory returns)
  always_comb begin
    w_accept      = (r_state == ST_REQ) && imem_ready &&
                    (!r_inst_valid || !stall) && !redirect_en;
    w_pc_next_seq = w_pc + PC_INC;
    w_pc_en       = redirect_en || w_accept;
    w_pc_d        = redirect_en ? {redirect_pc[15:1], 1'b0} : w_pc_next_seq;
  end

  pc_reg #(.DATA_W(16), .RESET_VAL(RESET_PC)) u_pc (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (w_pc_en),
    .i_d   (w_pc_d),
    .o_q   (w_pc)
  );

  pc_reg #(.DATA_W(16), .RESET_VAL(16'h0000)) u_inst (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (w_accept),
    .i_d   (imem_rdata),
    .o_q   (instruction)
  );

  pc_reg #(.DATA_W(16), .RESET_VAL(16'h0000)) u_pc_inc (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (w_accept),
    .i_d   (w_pc_next_seq),
    .o_q   (pc_inc)
  );

  // Fetch control FSM: slot valid, hold/halt state and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_REQ;
      r_inst_valid <= 1'b0;
      r_err        <= 1'b0;
`ifdef FETCH_HALT_EN
      r_halted     <= 1'b0;
`endif
    end else if (redirect_en) begin
      r_state      <= ST_REQ;
      r_inst_valid <= 1'b0;
      if (redirect_pc[0])
        r_err <= 1'b1;
`ifdef FETCH_HALT_EN
      r_halted     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_accept) begin
            r_inst_valid <= 1'b1;
`ifdef FETCH_HALT_EN
            if (is_halt(imem_rdata)) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end
`endif
          end else if (r_inst_valid && stall) begin
            r_state <= ST_HOLD;
          end else if (r_inst_valid) begin
            r_inst_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            r_inst_valid <= 1'b0;
            r_state      <= ST_REQ;
          end
        end
        ST_HALT: begin
          if (r_inst_valid && !stall)
            r_inst_valid <= 1'b0;
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

  assign imem_req   = (r_state == ST_REQ);
  assign imem_addr  = w_pc;
  assign inst_valid = r_inst_valid;
  assign err        = r_err;
`ifdef FETCH_HALT_EN
  assign halted     = r_halted;
`else
  assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed testbench for the fetch stage. Memory returns 16'h4000+addr
// unless an override address/data pair is armed.
module tb_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] instruction;
  logic [15:0] pc_inc;
  logic        inst_valid;
  logic        halted;
  logic        err;

  logic        ovr_en;
  logic [15:0] ovr_addr;
  logic [15:0] ovr_data;

  int n_checks;
  int n_errors;

  fetch #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc_inc      (pc_inc),
    .inst_valid  (inst_valid),
    .halted      (halted),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = (ovr_en && imem_addr == ovr_addr) ? ovr_data
                                                        : 16'h4000 + imem_addr;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 16'h0000;
    imem_ready  = 1'b0;
    ovr_en      = 1'b0;
    ovr_addr    = 16'h0000;
    ovr_data    = 16'h0000;
    step();
    step();

    // Reset state
    check("rst_addr",   imem_addr,   16'h0000);
    check("rst_req",    imem_req,    16'h1);
    check("rst_valid",  inst_valid,  16'h0);
    check("rst_inst",   instruction, 16'h0000);
    check("rst_pcinc",  pc_inc,      16'h0000);
    check("rst_halted", halted,      16'h0);
    check("rst_err",    err,         16'h0);

    // Streaming fetch
    rst        = 1'b0;
    imem_ready = 1'b1;
    check("s_addr0", imem_addr, 16'h0000);
    step();
    check("s_addr1", imem_addr,   16'h0002);
    check("s_inst1", instruction, 16'h4000);
    check("s_pinc1", pc_inc,      16'h0002);
    check("s_vld1",  inst_valid,  16'h1);
    step();
    check("s_addr2", imem_addr,   16'h0004);
    check("s_inst2", instruction, 16'h4002);
    check("s_pinc2", pc_inc,      16'h0004);

    // Memory wait at 0x0004
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("w_req",  imem_req,   16'h1);
      check("w_addr", imem_addr,  16'h0004);
      check("w_vld",  inst_valid, 16'h0);
    end
    imem_ready = 1'b1;
    ovr_en     = 1'b1;
    ovr_addr   = 16'h0006;
    ovr_data   = 16'hA123;
    step();
    check("w_inst", instruction, 16'h4004);
    check("w_pinc", pc_inc,      16'h0006);
    step();
    check("st_inst0", instruction, 16'hA123);
    check("st_addr0", imem_addr,   16'h0008);

    // Decode stall for four cycles
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("st_inst", instruction, 16'hA123);
      check("st_req",  imem_req,    16'h0);
      check("st_addr", imem_addr,   16'h0008);
      check("st_vld",  inst_valid,  16'h1);
    end
    stall = 1'b0;
    step();
    check("st_rel_vld", inst_valid, 16'h0);
    check("st_rel_req", imem_req,   16'h1);
    step();
    check("st_res_inst", instruction, 16'h4008);
    check("st_res_addr", imem_addr,   16'h000A);
    check("st_res_vld",  inst_valid,  16'h1);

    // Redirect beats ready and stall in the same cycle
    stall       = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 16'h0100;
    step();
    check("rd_vld",  inst_valid,  16'h0);
    check("rd_addr", imem_addr,   16'h0100);
    check("rd_inst", instruction, 16'h4008);
    redirect_en = 1'b0;
    stall       = 1'b0;
    step();
    check("rd_next_inst", instruction, 16'h4100);
    check("rd_next_pinc", pc_inc,      16'h0102);
    check("rd_err0",      err,         16'h0);

    // Misaligned redirect
    redirect_en = 1'b1;
    redirect_pc = 16'h0101;
    step();
    check("mis_err",  err,       16'h1);
    check("mis_addr", imem_addr, 16'h0100);
    redirect_en = 1'b0;
    step();
    check("mis_sticky", err,         16'h1);
    check("mis_inst",   instruction, 16'h4100);

    // Asynchronous reset with a request outstanding
    rst = 1'b1;
    #1;
    check("ar_err",   err,         16'h0);
    check("ar_addr",  imem_addr,   16'h0000);
    check("ar_vld",   inst_valid,  16'h0);
    check("ar_inst",  instruction, 16'h0000);
    @(negedge clk);
    imem_ready = 1'b0;
    rst        = 1'b0;
    step();
    check("ar_req1",  imem_req,  16'h1);
    check("ar_addr1", imem_addr, 16'h0000);

    // HALT opcode at 0x0006
    imem_ready = 1'b1;
    ovr_addr   = 16'h0006;
    ovr_data   = 16'h0000;
    step();
    step();
    step();
    check("h_addr6", imem_addr, 16'h0006);
    step();
    check("h_inst", instruction, 16'h0000);
    check("h_vld",  inst_valid,  16'h1);
    check("h_addr", imem_addr,   16'h0008);
`ifdef FETCH_HALT_EN
    check("h_halted", halted,   16'h1);
    check("h_req",    imem_req, 16'h0);
    step();
    check("h_vld2",    inst_valid, 16'h0);
    check("h_halted2", halted,     16'h1);
    check("h_req2",    imem_req,   16'h0);
    check("h_addr2",   imem_addr,  16'h0008);
    redirect_en = 1'b1;
    redirect_pc = 16'h0020;
    step();
    check("h_rd_halted", halted,    16'h0);
    check("h_rd_addr",   imem_addr, 16'h0020);
    check("h_rd_req",    imem_req,  16'h1);
    redirect_en = 1'b0;
    step();
    check("h_res_inst", instruction, 16'h4020);
    check("h_res_addr", imem_addr,   16'h0022);
`else
    check("nh_halted", halted,   16'h0);
    check("nh_req",    imem_req, 16'h1);
    step();
    check("nh_inst", instruction, 16'h4008);
    check("nh_addr", imem_addr,   16'h000A);
`endif

    // PC wrap from 0xFFFE
    redirect_en = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    check("wr_addr", imem_addr, 16'hFFFE);
    redirect_en = 1'b0;
    step();
    check("wr_inst", instruction, 16'h3FFE);
    check("wr_pinc", pc_inc,      16'h0000);
    check("wr_addr0", imem_addr,  16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
